hilo_muldiv_ctrl: RTL

- Owns the HI/LO register pair.
- Sequences MULT/MULTU/DIV/DIVU/MTHI/MTLO for the EX stage of the 5-stage MIPS pipeline.
- Runs a 1-cycle registered multiply and a 32-iteration radix-2 restoring divider.
- Holds the pipeline with `stall` until the result is committed to HI/LO.
- MFHI/MFLO read `hi`/`lo` directly, selected by the decoder's `memtoreg`.

---
 rtl/hilo_muldiv_ctrl_if.sv | 44 ++++
 rtl/hilo_muldiv_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_ctrl_if.sv
// ----------------------------------------------------------------------------
// hilo_muldiv_ctrl_if
//
// Purpose:
//   Bundles the EX-stage request signals and the HI/LO controller responses
//   of hilo_muldiv_ctrl into one interface.
//
// Signals:
//   start  - EX holds a valid HI/LO instruction
//   op     - 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, others no-op
//   src_a  - rs value (dividend / multiplicand / MTHI, MTLO data)
//   src_b  - rt value (divisor / multiplier)
//   cancel - EX flush (only honoured when MULDIV_CANCEL_EN is defined)
//   stall  - hold IF/ID/EX
//   busy   - controller FSM not idle
//   done   - one-cycle pulse in the commit cycle
//   hi, lo - architectural HI/LO registers
//
// Modports:
//   master - EX stage side (drives the request)
//   slave  - hilo_muldiv_ctrl side (drives the response)
// ----------------------------------------------------------------------------
interface hilo_muldiv_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, src_a, src_b, cancel,
        input  stall, busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, cancel,
        output stall, busy, done, hi, lo
    );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// ----------------------------------------------------------------------------
// hilo_muldiv_ctrl
//
// Purpose:
//   Owns the MIPS HI/LO register pair and sequences MULT/MULTU/DIV/DIVU/
//   MTHI/MTLO for the EX stage. Multiplies take one registered cycle, divides
//   use a 32-iteration radix-2 restoring divider. The pipeline is held with
//   stall until the result is committed to HI/LO.
//
// Ports:
//   clk    - pipeline clock
//   resetn - asynchronous active-low reset
//   bus    - hilo_muldiv_ctrl_if.slave (start/op/src_a/src_b/cancel in,
//            stall/busy/done/hi/lo out)
//
// Configuration:
//   MULDIV_CANCEL_EN - when defined, bus.cancel aborts an operation in
//                      progress and suppresses start in IDLE. When undefined,
//                      cancel is ignored and every accepted op completes.
// ----------------------------------------------------------------------------
module hilo_muldiv_ctrl (
    input  logic                 clk,
    input  logic                 resetn,
    hilo_muldiv_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t      state;
    state_t      state_next;

    logic [31:0] hi_q;
    logic [31:0] lo_q;

    // op_a keeps the raw rs value (needed for divide-by-zero), op_b keeps the
    // multiplier or the divisor magnitude.
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        mul_signed;
    logic        quo_neg;
    logic        rem_neg;
    logic        div_zero;
    logic [4:0]  count;
    logic [63:0] rq;
    logic [63:0] result;

    logic        cancel_eff;
    logic        accept;
    logic        is_mul_op;
    logic        is_div_op;
    logic        div_signed_op;

    logic [31:0] a_mag;
    logic [31:0] b_mag;

    logic [63:0] mul_a64;
    logic [63:0] mul_b64;
    logic [63:0] product;

    logic [32:0] partial;
    logic        fits;
    logic [31:0] diff;
    logic [63:0] rq_step;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [63:0] div_result;

`ifdef MULDIV_CANCEL_EN
    assign cancel_eff = bus.cancel;
`else
    logic unused_cancel;
    assign unused_cancel = bus.cancel;
    assign cancel_eff    = 1'b0;
`endif

    assign accept        = bus.start & ~cancel_eff;
    assign is_mul_op     = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    assign is_div_op     = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign div_signed_op = (bus.op == OP_DIV);

    assign a_mag = (div_signed_op && bus.src_a[31]) ? (32'd0 - bus.src_a) : bus.src_a;
    assign b_mag = (div_signed_op && bus.src_b[31]) ? (32'd0 - bus.src_b) : bus.src_b;

    // The low 64 bits of a product do not depend on operand signedness once
    // both operands are extended to 64 bits, so one unsigned multiplier
    // serves MULT and MULTU.
    assign mul_a64 = {{32{mul_signed & op_a[31]}}, op_a};
    assign mul_b64 = {{32{mul_signed & op_b[31]}}, op_b};
    assign product = mul_a64 * mul_b64;

    // One restoring step. rq holds {remainder, dividend/quotient}. The shifted
    // partial remainder needs 33 bits because DIVU divisors can use all 32
    // bits; when it fits, the true difference is below the divisor so the
    // low 32 bits of the subtraction are exact.
    assign partial = rq[63:31];
    assign fits    = (partial >= {1'b0, op_b});
    assign diff    = partial[31:0] - op_b;
    assign rq_step = fits ? {diff, rq[30:0], 1'b1}
                          : {partial[31:0], rq[30:0], 1'b0};

    assign quo_mag = rq_step[31:0];
    assign rem_mag = rq_step[63:32];

    // Divide by zero bypasses the sign fixup and returns the raw rs in HI.
    assign div_result = div_zero ? {op_a, 32'hFFFF_FFFF}
                                 : {(rem_neg ? (32'd0 - rem_mag) : rem_mag),
                                    (quo_neg ? (32'd0 - quo_mag) : quo_mag)};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Stall in IDLE is qualified with resetn so the pipeline is released the
    // moment reset is asserted, even while EX still presents start.
    always_comb begin
        state_next = state;
        bus.stall  = 1'b0;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                if (accept && is_mul_op) begin
                    state_next = MUL;
                end else if (accept && is_div_op) begin
                    state_next = DIV;
                end
                bus.stall = resetn & accept & (is_mul_op | is_div_op);
            end
            MUL: begin
                state_next = cancel_eff ? IDLE : DONE;
                bus.stall  = ~cancel_eff;
                bus.busy   = 1'b1;
            end
            DIV: begin
                if (cancel_eff) begin
                    state_next = IDLE;
                end else if (count == 5'd31) begin
                    state_next = DONE;
                end
                bus.stall = ~cancel_eff;
                bus.busy  = 1'b1;
            end
            DONE: begin
                state_next = IDLE;
                bus.busy   = 1'b1;
                bus.done   = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath. Operands are captured only in IDLE so later changes on
    // src_a/src_b while stalled have no effect. The divider loads the dividend
    // magnitude into the low half of rq with a cleared remainder half.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            op_a       <= 32'd0;
            op_b       <= 32'd0;
            mul_signed <= 1'b0;
            quo_neg    <= 1'b0;
            rem_neg    <= 1'b0;
            div_zero   <= 1'b0;
            count      <= 5'd0;
            rq         <= 64'd0;
            result     <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU: begin
                                op_a       <= bus.src_a;
                                op_b       <= bus.src_b;
                                mul_signed <= (bus.op == OP_MULT);
                            end
                            OP_DIV, OP_DIVU: begin
                                op_a     <= bus.src_a;
                                op_b     <= b_mag;
                                rq       <= {32'd0, a_mag};
                                count    <= 5'd0;
                                quo_neg  <= div_signed_op & (bus.src_a[31] ^ bus.src_b[31]);
                                rem_neg  <= div_signed_op & bus.src_a[31];
                                div_zero <= (bus.src_b == 32'd0);
                            end
                            OP_MTHI: begin
                                hi_q <= bus.src_a;
                            end
                            OP_MTLO: begin
                                lo_q <= bus.src_a;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                MUL: begin
                    result <= product;
                end
                DIV: begin
                    rq    <= rq_step;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        result <= div_result;
                    end
                end
                DONE: begin
                    hi_q <= result[63:32];
                    lo_q <= result[31:0];
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.hi = hi_q;
    assign bus.lo = lo_q;

endmodule
